uart_frame_tx: RTL

//   Downstream stage of the protocol encoder. Accepts the encoded bytes it produces:
//   0xFF frame start, 0x01/0x02 switcher ON/OFF, or raw frequency data.

---
 rtl/uart_frame_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   FIFO-buffered UART transmitter for the protocol encoder's output bytes.
//   Each byte is sent LSB first as 8N1, or as 8E1 when UART_TX_PARITY_EN is
//   defined. Characters go back-to-back while the FIFO holds data.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_AW       FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   byte_in     byte to transmit
//   byte_valid  byte_in valid this cycle
//   byte_ready  FIFO not full; byte accepted when byte_valid & byte_ready
//   tx          serial output, idle high
//   busy        FSM active or FIFO non-empty
//   tx_done     one-cycle pulse on the last cycle of each stop bit
//
// Build option
//   UART_TX_PARITY_EN  insert an even-parity bit between data and stop
module uart_frame_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_AW      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] FULL      = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   // FIFO
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [7:0]         head;
   logic               push;
   logic               pop;

   // Serialiser
   state_t      state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]  bit_idx, bit_n;
   logic [7:0]  shift, shift_n;
   logic        tx_q, tx_n;
   logic        done_q, done_n;
`ifdef UART_TX_PARITY_EN
   logic        parity, parity_n;
`endif

   assign byte_ready = (count != FULL);
   assign push       = byte_valid & byte_ready;
   assign head       = mem[rd_ptr];
   assign busy       = (state != ST_IDLE) || (count != '0);
   assign tx         = tx_q;
   assign tx_done    = done_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= byte_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW + 1)'(1);
            2'b01:   count <= count - (FIFO_AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud + BW'(1);
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_n = parity;
`endif

      case (state)
         ST_IDLE: begin
            baud_n = '0;
            if (count != '0) begin
               pop     = 1'b1;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               shift_n = {1'b0, shift[7:1]};
               bit_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               state_n = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               // Chain straight into the next start bit when data is waiting.
               if (count != '0) begin
                  pop     = 1'b1;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: begin
            baud_n  = '0;
            state_n = ST_IDLE;
         end
      endcase

      if (pop) begin
         shift_n = head;
`ifdef UART_TX_PARITY_EN
         parity_n = ^head;
`endif
      end

      // tx and tx_done are registered from next-state values so they line up
      // with the state register without a combinational output path.
      tx_n = 1'b1;
      if (state_n == ST_START) begin
         tx_n = 1'b0;
      end else if (state_n == ST_DATA) begin
         tx_n = shift_n[0];
      end
`ifdef UART_TX_PARITY_EN
      else if (state_n == ST_PARITY) begin
         tx_n = parity_n;
      end
`endif
      done_n = (state_n == ST_STOP) && (baud_n == BAUD_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         tx_q    <= tx_n;
         done_q  <= done_n;
`ifdef UART_TX_PARITY_EN
         parity  <= parity_n;
`endif
      end
   end

endmodule
